// File: rtl/fpga_top_lite_pkg.sv
// Shared geometry, configuration-row field offsets and row layout types for the lite fabric.
// Optional scan chain is selected with the SCAN_CHAIN_EN macro (see fpga_top_lite).
package fpga_top_lite_pkg;

    localparam int unsigned DEF_N_IO    = 8;
    localparam int unsigned DEF_N_LUT   = 4;
    localparam int unsigned DEF_K       = 4;
    localparam int unsigned DEF_SEL_W   = $clog2(DEF_N_IO + DEF_N_LUT);
    localparam int unsigned DEF_TRUTH_W = 2 ** DEF_K;
    localparam int unsigned DEF_BL_W    = DEF_TRUTH_W + DEF_K * DEF_SEL_W + 1;
    localparam int unsigned DEF_WL_W    = DEF_N_LUT + DEF_N_IO;

    // A single-LUT fabric still needs a one-bit source field in the pad row.
    function automatic int unsigned lidx_width(input int unsigned n_lut);
        return (n_lut > 1) ? $clog2(n_lut) : 1;
    endfunction

    localparam int unsigned DEF_LIDX_W = lidx_width(DEF_N_LUT);

    localparam int unsigned LUT_TRUTH_LSB  = 0;
    localparam int unsigned LUT_SEL_LSB    = DEF_TRUTH_W;
    localparam int unsigned LUT_BYPASS_BIT = DEF_TRUTH_W + DEF_K * DEF_SEL_W;
    localparam int unsigned PAD_OE_BIT     = 0;
    localparam int unsigned PAD_SRC_LSB    = 1;

    typedef struct packed {
        logic                                bypass;
        logic [DEF_K-1:0][DEF_SEL_W-1:0]     sel;
        logic [DEF_TRUTH_W-1:0]              truth;
    } lut_cfg_t;

    typedef struct packed {
        logic [DEF_BL_W-2-DEF_LIDX_W:0]      rsvd;
        logic [DEF_LIDX_W-1:0]               src;
        logic                                oe;
    } pad_cfg_t;

endpackage

// File: rtl/fpga_lut_cell.sv
// One logic cell: K crossbar input selects, 2^K truth table, output FF and bypass mux.
// Shift inputs are only driven when the fabric is built with SCAN_CHAIN_EN.
module fpga_lut_cell
    import fpga_top_lite_pkg::*;
#(
    parameter int unsigned N_SRC = DEF_N_IO + DEF_N_LUT,
    parameter int unsigned K     = DEF_K,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                 clk,
    input  logic                 global_resetn,
    input  logic                 shift_en,
    input  logic                 shift_in,
    input  logic [2**K-1:0]      truth,
    input  logic [K*SEL_W-1:0]   sel,
    input  logic                 bypass,
    input  logic [N_SRC-1:0]     src_bus,
    output logic                 lut_out,
    output logic                 ff_q
);

    logic [K-1:0] lut_in;
    logic         lut_comb;

    // Select codes beyond the source bus read as constant 0.
    always_comb begin
        lut_in = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (32'(sel[j*SEL_W +: SEL_W]) < N_SRC) begin
                lut_in[j] = src_bus[sel[j*SEL_W +: SEL_W]];
            end
        end
    end

    assign lut_comb = truth[lut_in];

    always_ff @(posedge clk) begin
        if (!global_resetn) begin
            ff_q <= 1'b0;
        end else if (shift_en) begin
            ff_q <= shift_in;
        end else begin
            ff_q <= lut_comb;
        end
    end

    assign lut_out = bypass ? lut_comb : ff_q;

endmodule

// File: rtl/fpga_top_lite.sv
// Miniature memory-bank configured fabric: BL/WL config rows, N_LUT cells, N_IO pads.
// Define SCAN_CHAIN_EN to chain the LUT FFs for scan shift; otherwise scan pins are unused.
module fpga_top_lite
    import fpga_top_lite_pkg::*;
#(
    parameter  int unsigned N_IO  = DEF_N_IO,
    parameter  int unsigned N_LUT = DEF_N_LUT,
    parameter  int unsigned K     = DEF_K,
    localparam int unsigned SEL_W = $clog2(N_IO + N_LUT),
    localparam int unsigned BL_W  = 2 ** K + K * SEL_W + 1,
    localparam int unsigned WL_W  = N_LUT + N_IO
) (
    input  logic            clk,
    input  logic            global_resetn,
    input  logic            scan_en,
    input  logic            scan_mode,
    input  logic [N_IO-1:0] gfpga_pad_QL_PREIO_A2F,
    output logic [N_IO-1:0] gfpga_pad_QL_PREIO_F2A,
    output logic [N_IO-1:0] gfpga_pad_QL_PREIO_F2A_CLK,
    input  logic [BL_W-1:0] bl_config_region_0,
    input  logic [WL_W-1:0] wl_config_region_0
);

    localparam int unsigned N_SRC   = N_IO + N_LUT;
    localparam int unsigned TRUTH_W = 2 ** K;
    localparam int unsigned LIDX_W  = lidx_width(N_LUT);

    // Configuration memory has no reset; it is written even while global_resetn is low.
    logic [BL_W-1:0] cfg_mem [WL_W];

    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < WL_W; r++) begin
            if (wl_config_region_0[r]) begin
                cfg_mem[r] <= bl_config_region_0;
            end
        end
    end

    logic [N_LUT-1:0] lut_out;
    logic [N_LUT-1:0] ff_q;
    logic [N_SRC-1:0] src_bus;
    logic             shift_en;
    logic [N_LUT-1:0] shift_in;
    logic [N_IO-1:0]  pad_f2a;

    assign src_bus = {lut_out, gfpga_pad_QL_PREIO_A2F};

`ifdef SCAN_CHAIN_EN
    assign shift_en = scan_mode & scan_en;

    always_comb begin
        shift_in    = '0;
        shift_in[0] = gfpga_pad_QL_PREIO_A2F[0];
        for (int unsigned n = 1; n < N_LUT; n++) begin
            shift_in[n] = ff_q[n-1];
        end
    end
`else
    logic unused_scan;

    assign shift_en    = 1'b0;
    assign shift_in    = '0;
    assign unused_scan = ^{scan_en, scan_mode, ff_q};
`endif

    for (genvar n = 0; n < N_LUT; n++) begin : g_lut
        logic [BL_W-1:0] row;

        assign row = cfg_mem[n];

        fpga_lut_cell #(
            .N_SRC (N_SRC),
            .K     (K),
            .SEL_W (SEL_W)
        ) u_cell (
            .clk           (clk),
            .global_resetn (global_resetn),
            .shift_en      (shift_en),
            .shift_in      (shift_in[n]),
            .truth         (row[TRUTH_W-1:0]),
            .sel           (row[TRUTH_W+K*SEL_W-1:TRUTH_W]),
            .bypass        (row[BL_W-1]),
            .src_bus       (src_bus),
            .lut_out       (lut_out[n]),
            .ff_q          (ff_q[n])
        );
    end

    for (genvar i = 0; i < N_IO; i++) begin : g_pad
        logic              pad_oe;
        logic [LIDX_W-1:0] pad_src;
        logic              pad_val;

        assign pad_oe  = cfg_mem[N_LUT+i][0];
        assign pad_src = cfg_mem[N_LUT+i][LIDX_W:1];
        assign pad_val = (32'(pad_src) < N_LUT) ? lut_out[pad_src] : 1'b0;

        assign pad_f2a[i]                    = pad_oe & pad_val;
        assign gfpga_pad_QL_PREIO_F2A_CLK[i] = pad_oe;
    end

`ifdef SCAN_CHAIN_EN
    // In scan mode the top pad observes the end of the chain regardless of its config.
    always_comb begin
        gfpga_pad_QL_PREIO_F2A = pad_f2a;
        if (scan_mode) begin
            gfpga_pad_QL_PREIO_F2A[N_IO-1] = ff_q[N_LUT-1];
        end
    end
`else
    assign gfpga_pad_QL_PREIO_F2A = pad_f2a;
`endif

endmodule

// File: tb/tb_fpga_top_lite.sv
// Directed bench for fpga_top_lite: AND2 map, chaining, registered path, config rows.
// Scan-chain vectors run only when SCAN_CHAIN_EN is defined.
module tb_fpga_top_lite;
    import fpga_top_lite_pkg::*;

    localparam int unsigned BL_W = DEF_BL_W;
    localparam int unsigned WL_W = DEF_WL_W;

    logic            clk = 1'b0;
    logic            resetn;
    logic            scan_en;
    logic            scan_mode;
    logic [7:0]      a2f;
    logic [7:0]      f2a;
    logic [7:0]      f2a_clk;
    logic [BL_W-1:0] bl_cfg;
    logic [WL_W-1:0] wl_cfg;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    fpga_top_lite #(
        .N_IO  (8),
        .N_LUT (4),
        .K     (4)
    ) dut (
        .clk                        (clk),
        .global_resetn              (resetn),
        .scan_en                    (scan_en),
        .scan_mode                  (scan_mode),
        .gfpga_pad_QL_PREIO_A2F     (a2f),
        .gfpga_pad_QL_PREIO_F2A     (f2a),
        .gfpga_pad_QL_PREIO_F2A_CLK (f2a_clk),
        .bl_config_region_0         (bl_cfg),
        .wl_config_region_0         (wl_cfg)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [BL_W-1:0] lut_row(input logic [15:0] truth,
                                                input logic [3:0] s0, input logic [3:0] s1,
                                                input logic [3:0] s2, input logic [3:0] s3,
                                                input logic byp);
        lut_cfg_t c;
        c.truth  = truth;
        c.sel[0] = s0;
        c.sel[1] = s1;
        c.sel[2] = s2;
        c.sel[3] = s3;
        c.bypass = byp;
        return c;
    endfunction

    function automatic logic [BL_W-1:0] pad_row(input logic oe, input logic [1:0] src);
        pad_cfg_t c;
        c.rsvd = '0;
        c.src  = src;
        c.oe   = oe;
        return c;
    endfunction

    function automatic logic [WL_W-1:0] row_bit(input int unsigned r);
        logic [WL_W-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic write_rows(input logic [WL_W-1:0] wl, input logic [BL_W-1:0] bl);
        @(negedge clk);
        bl_cfg = bl;
        wl_cfg = wl;
        @(negedge clk);
        wl_cfg = '0;
    endtask

    // {a, b}; a on A2F[0], b on A2F[1]
    logic [1:0] and_vec [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    logic       and_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] chn_vec [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
    logic [7:0] chn_exp [4] = '{8'h08, 8'h04, 8'h08, 8'h08};

    initial begin
        resetn    = 1'b0;
        scan_en   = 1'b0;
        scan_mode = 1'b0;
        a2f       = '0;
        bl_cfg    = '0;
        wl_cfg    = '0;
        repeat (2) @(negedge clk);

        write_rows('1, '0);
        #1;
        check("reset_f2a", f2a, 8'h00);
        check("reset_oe", f2a_clk, 8'h00);

        write_rows(row_bit(0), lut_row(16'h8888, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1));
        write_rows(row_bit(DEF_N_LUT + 2), pad_row(1'b1, 2'd0));
        a2f = 8'h03;
        #1;
        check("in_reset_and", f2a, 8'h04);
        check("in_reset_oe", f2a_clk, 8'h04);

        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a2f = {6'b0, and_vec[i][0], and_vec[i][1]};
            #1;
            check($sformatf("and2_%0d", i), {7'b0, f2a[2]}, {7'b0, and_exp[i]});
        end
        check("and2_oe", f2a_clk, 8'b0000_0100);

        write_rows(row_bit(1), lut_row(16'h5555, 4'd8, 4'd0, 4'd0, 4'd0, 1'b1));
        write_rows(row_bit(DEF_N_LUT + 3), pad_row(1'b1, 2'd1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a2f = {6'b0, chn_vec[i][0], chn_vec[i][1]};
            #1;
            check($sformatf("chain_%0d", i), f2a, chn_exp[i]);
        end
        check("chain_oe", f2a_clk, 8'h0C);

        @(negedge clk);
        resetn = 1'b0;
        a2f    = 8'h03;
        write_rows(row_bit(0), lut_row(16'h8888, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0));
        #1;
        check("reg_in_reset", f2a, 8'h08);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reg_pre_edge", f2a, 8'h08);
        @(posedge clk);
        #1;
        check("reg_post_edge", f2a, 8'h04);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("reg_rst_pre_edge", f2a, 8'h04);
        @(posedge clk);
        #1;
        check("reg_rst_post_edge", f2a, 8'h08);

        @(negedge clk);
        resetn = 1'b1;
        write_rows(row_bit(0), lut_row(16'h8888, 4'd15, 4'd1, 4'd0, 4'd0, 1'b1));
        #1;
        check("sel_out_of_range", f2a, 8'h08);

        write_rows('1, '0);
        #1;
        check("multi_row_f2a", f2a, 8'h00);
        check("multi_row_oe", f2a_clk, 8'h00);

`ifdef SCAN_CHAIN_EN
        @(negedge clk);
        scan_mode = 1'b1;
        scan_en   = 1'b1;
        a2f       = 8'h00;
        repeat (4) @(negedge clk);
        #1;
        check("scan_flush", f2a, 8'h00);
        @(negedge clk);
        a2f = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("scan_3_edges", f2a, 8'h00);
        @(posedge clk);
        #1;
        check("scan_4_edges", f2a, 8'h80);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("scan_reset_prio", f2a, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpga_top_lite.md
Name: fpga_top_lite

Overview:
- Miniature memory-bank-configured FPGA fabric: N_LUT K-input LUT cells, a crossbar input-select per LUT input, an optional register per LUT, and N_IO fabric I/O pads.
- Configuration is written through bit-line (BL) and word-line (WL) vectors into a row-addressed configuration memory.
- User logic such as a 2-input AND mapped onto it runs from pad inputs to pad outputs.
- Top level of the fabric; testbenches drive pads and config lines directly.

Parameters:
- N_IO, 8, number of I/O pads.
- N_LUT, 4, number of logic cells.
- K, 4, LUT inputs (truth table is 2^K bits).
- SEL_W, derived $clog2(N_IO+N_LUT), LUT input-select width.
- BL_W, derived 2^K + K*SEL_W + 1, configuration row width (33 at defaults).
- WL_W, derived N_LUT + N_IO, number of configuration rows (12 at defaults).

Ports:
- clk  in  1  sole clock; rising edge.
- global_resetn  in  1  synchronous active-low reset.
- scan_en  in  1  scan shift enable.
- scan_mode  in  1  scan test mode.
- gfpga_pad_QL_PREIO_A2F  in  N_IO  pad-to-fabric inputs.
- gfpga_pad_QL_PREIO_F2A  out  N_IO  fabric-to-pad outputs.
- gfpga_pad_QL_PREIO_F2A_CLK  out  N_IO  per-pad output-enable (1 = fabric drives pad).
- bl_config_region_0  in  BL_W  config bit-line data.
- wl_config_region_0  in  WL_W  config word-line row strobes.

Behaviour:
- Config write: on each rising clk, every row r with wl[r]=1 loads bl[BL_W-1:0]; multiple strobes write the same data to each strobed row; wl all-zero holds contents.
- Config memory is not affected by global_resetn; writes work while in reset.
- Config memory is uninitialised until written.
- LUT row r (r < N_LUT) layout, LSB first:
  - truth[2^K-1:0].
  - sel0..sel(K-1), SEL_W each.
  - bypass bit: 1 = combinational output, 0 = registered.
- Pad row N_LUT+i layout:
  - bit0 = oe.
  - bits[$clog2(N_LUT):1] = source LUT index.
  - remaining bits ignored.
- LUT input source sel s:
  - s < N_IO selects A2F[s].
  - s < N_IO+N_LUT selects LUT output s-N_IO.
  - out-of-range s gives 0.
- LUT index = {in(K-1)..in0}; lut_comb = truth[index].
- Each LUT FF updates from lut_comb on rising clk; global_resetn=0 clears every FF to 0 synchronously.
- LUT output = bypass ? lut_comb : FF.
- F2A[i] = oe ? LUT output[src] : 0; F2A_CLK[i] = oe.
- A fully combinational path (bypass=1) has zero-cycle latency, independent of clk and reset.
- Combinational loops between bypassed LUTs are a configuration error; no detection is required.
- When global_resetn=0, all outputs are driven from the current configuration, with all FFs at 0.

Optional Feature:
- SCAN_CHAIN_EN defined:
  - When scan_mode=1 and scan_en=1, LUT FFs form a shift chain FF0 <- A2F[0], FFn <- FF(n-1).
  - F2A[N_IO-1] is forced to FF(N_LUT-1).
  - Reset has priority over shifting.
- SCAN_CHAIN_EN undefined: scan_en and scan_mode are ignored (no logic).

Decomposition:
- Package fpga_top_lite_pkg holds:
  - row-field offset constants for the LUT and pad rows;
  - typedefs lut_cfg_t and pad_cfg_t (packed structs matching the row layouts).
- One natural sub-module: fpga_lut_cell (truth table, K input muxes, FF, bypass mux), instantiated N_LUT times.

Test Plan:
- AND2 map:
  - Program row0 truth=16'h8888, sel0=0, sel1=1, sel2/sel3=0, bypass=1.
  - Program row N_LUT+2 oe=1, src=0; other pad rows 0.
  - Release reset, then apply (a,b) on A2F[0],A2F[1] for 00,01,10,11,01,10,11 -> F2A[2] reads 0,0,0,1,0,0,1 within the same timestep.
  - F2A_CLK = 8'b0000_0100.
- Registered path: same map with bypass=0, a=b=1 -> F2A[2]=0 until the first rising clk with reset high, then 1. Reset low -> 0 on the next edge.
- Multi-row write: assert wl=all ones with bl=0 -> all pad outputs 0 and F2A_CLK=0.
- LUT chaining: LUT1 sel0=N_IO+0 (LUT0 output), truth=16'h5555 (inverter), bypass=1, pad3 src=1 -> F2A[3] = ~(a&b).
- Config during reset: write config with global_resetn=0 -> contents retained after reset release; AND2 check passes.
- With SCAN_CHAIN_EN defined: scan_mode=scan_en=1, A2F[0]=1 for N_LUT cycles -> F2A[N_IO-1]=1 after N_LUT edges.
